seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Bit-serial pattern transmitter: drives the single-bit serial input A consumed by the
//  sequence-detector machine. Emits a latched PAT_W-bit pattern MSB-first, one bit per clk,
//  repeated a programmable number of times. Used as the stimulus source and loopback driver.
// PARAMETERS
//  PAT_W    4        pattern width in bits (>=2)
//  CNT_W    4        width of repetition counter / repeat_cnt port
//  GAP_CYC  2        idle (A=0) cycles between repetitions; used only when SEQGEN_GAP_EN defined
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  abort       in   1      synchronous cancel of an active transfer
//  pattern     in   PAT_W  pattern to send, bit PAT_W-1 first; latched on accepted start
//  repeat_cnt  in   CNT_W  number of repetitions; latched on accepted start
//  A           out  1      serial data to detector (registered)
//  bit_valid   out  1      high in every cycle A carries a pattern bit
//  busy        out  1      high from the accepting edge until the final bit has been sent
//  done        out  1      one-cycle pulse after the final bit of the final repetition
// BEHAVIOUR
//  - Reset (async): A=0, bit_valid=0, busy=0, done=0, state IDLE, all counters 0.
//  - All outputs registered; no combinational path from any input to any output.
//  - FSM states (seqgen_pkg::state_t): IDLE, SHIFT, GAP, FIN.
//  - IDLE: start=1 at edge N with repeat_cnt!=0 -> latch pattern/repeat_cnt; after edge N:
//    SHIFT, A=pattern[PAT_W-1], bit_valid=1, busy=1 (1-cycle latency start->first bit).
//  - IDLE, start=1, repeat_cnt==0 -> FIN directly; no bits; busy=1 for one cycle,
//    then done=1 for one cycle.
//  - SHIFT: each edge advances bit index; after bit 0 of a repetition:
//    more reps left -> next rep (SHIFT, or GAP with macro); last rep -> FIN.
//  - FIN (1 cycle): A=0, bit_valid=0, busy=0, done=1; next edge -> IDLE, done=0.
//  - start while busy=1 is ignored (no re-latch). start during done=1 is not accepted.
//    It is accepted on the following IDLE cycle.
//  - abort=1 in SHIFT/GAP: next edge -> IDLE; A=0, bit_valid=0, busy=0; done NOT pulsed.
//    abort has priority over start. abort in IDLE/FIN has no effect.
//  - Counters: bit index $clog2(PAT_W) bits, counts PAT_W-1 down to 0, no wrap-around.
//    Rep counter CNT_W bits, decremented per completed repetition, terminal at 1.
//  - Total busy cycles = repeat_cnt*PAT_W (+ (repeat_cnt-1)*GAP_CYC with macro).
//  - Reset asserted mid-transfer: outputs clear immediately, with no done pulse.
//    Transmission resumes only on a new start.
// CONFIGURATION
//  SEQGEN_GAP_EN defined: after each non-final repetition, state GAP holds A=0 and
//    bit_valid=0 (busy stays 1) for exactly GAP_CYC cycles.
//    This guarantees separated patterns for a non-overlapping detector.
//  SEQGEN_GAP_EN undefined: repetitions are sent back-to-back.
//    The GAP state and gap counter are not synthesised.
// STRUCTURE
//  seqgen_pkg: state_t enum (IDLE,SHIFT,GAP,FIN), DEFAULT_PATTERN = 4'b1101,
//    DEFAULT_GAP_CYC constant.
//  Sub-module seqgen_piso: PAT_W parallel-in/serial-out shift register with
//    load/shift/clear and async reset.
//  Top keeps the FSM, rep/gap counters and output registers.
// TESTING
//  1. pattern=4'b1101, repeat_cnt=1, start pulse
//     -> A=1,1,0,1 on 4 consecutive cycles, bit_valid=1 x4, done=1 on the 5th cycle.
//  2. pattern=1101, repeat_cnt=3, macro off
//     -> 12 contiguous bits 110111011101, busy=12 cycles, single done pulse.
//  3. Same as 2 with SEQGEN_GAP_EN, GAP_CYC=2
//     -> 1101 00 1101 00 1101 with bit_valid=0 in gaps, busy=16 cycles.
//  4. abort on the 2nd bit of repetition 2 (repeat_cnt=3)
//     -> next cycle A=0, busy=0, no done; a new start is accepted the cycle after.
//  5. reset pulse mid-SHIFT
//     -> A/busy/bit_valid drop to 0 without waiting for clk; no done.
//     Then repeat_cnt=0 start -> no bits, busy 1 cycle, then done 1 cycle.
//  6. Loopback into the detector with pattern 1101, repeat_cnt=2
//     -> detector Z asserts once per repetition.
//     Start held high during busy is ignored.

Source files
------------

// File: rtl/seqgen_pkg.sv
// rtl/seqgen_pkg.sv - shared types and constants for the serial pattern generator
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    FIN
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;
  localparam int         DEFAULT_GAP_CYC = 2;

endpackage

// File: rtl/seqgen_piso.sv
// rtl/seqgen_piso.sv - parallel-in/serial-out shift register, MSB first
module seqgen_piso #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         clear_i,
  input  logic [W-1:0] din_i,
  output logic         sout_o
);

  logic [W-1:0] sr_q, sr_d;

  // Zeros are shifted in, so the register drains to 0 after the last bit.
  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = din_i;
    end else if (shift_i) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - repeating bit-serial pattern transmitter
// SEQGEN_GAP_EN inserts GAP_CYC idle cycles between repetitions.
module seq_pattern_gen
  import seqgen_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = DEFAULT_GAP_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             A,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int               BIT_W   = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(PAT_W - 1);

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   rep_q, rep_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               fin_wait_q, fin_wait_d;
  logic               bv_q, bv_d, busy_q, busy_d, done_q, done_d;
  logic               piso_load, piso_shift, piso_clear;
  logic [PAT_W-1:0]   load_data;

`ifdef SEQGEN_GAP_EN
  localparam int               GAP_W    = $clog2(GAP_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  logic [GAP_W-1:0] gap_q, gap_d;
`else
  logic unused_gap_cyc;
  assign unused_gap_cyc = ^GAP_CYC;
`endif

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rep_d      = rep_q;
    bit_d      = bit_q;
    fin_wait_d = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;
    piso_clear = 1'b0;
    load_data  = pat_q;
`ifdef SEQGEN_GAP_EN
    gap_d      = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d = pattern;
          rep_d = repeat_cnt;
          if (repeat_cnt != '0) begin
            state_d   = SHIFT;
            bit_d     = BIT_MAX;
            piso_load = 1'b1;
            load_data = pattern;
          end else begin
            // Empty request: one busy cycle in FIN before the done pulse.
            state_d    = FIN;
            fin_wait_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d    = IDLE;
          piso_clear = 1'b1;
          bit_d      = '0;
          rep_d      = '0;
        end else if (bit_q == '0) begin
          if (rep_q == CNT_W'(1)) begin
            state_d    = FIN;
            piso_shift = 1'b1;
            rep_d      = '0;
          end else begin
            rep_d = rep_q - CNT_W'(1);
`ifdef SEQGEN_GAP_EN
            state_d    = GAP;
            gap_d      = GAP_LAST;
            piso_clear = 1'b1;
`else
            bit_d     = BIT_MAX;
            piso_load = 1'b1;
`endif
          end
        end else begin
          bit_d      = bit_q - BIT_W'(1);
          piso_shift = 1'b1;
        end
      end
      GAP: begin
`ifdef SEQGEN_GAP_EN
        if (abort) begin
          state_d    = IDLE;
          piso_clear = 1'b1;
          rep_d      = '0;
          gap_d      = '0;
        end else if (gap_q == '0) begin
          state_d   = SHIFT;
          bit_d     = BIT_MAX;
          piso_load = 1'b1;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      FIN: begin
        state_d = fin_wait_q ? FIN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    bv_d   = (state_d == SHIFT);
    busy_d = (state_d == SHIFT) || (state_d == GAP) || fin_wait_d;
    done_d = (state_d == FIN) && !fin_wait_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pat_q      <= '0;
      rep_q      <= '0;
      bit_q      <= '0;
      fin_wait_q <= 1'b0;
      bv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      rep_q      <= rep_d;
      bit_q      <= bit_d;
      fin_wait_q <= fin_wait_d;
      bv_q       <= bv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef SEQGEN_GAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`endif

  seqgen_piso #(.W(PAT_W)) u_piso (
    .clk_i   (clk),
    .rst_i   (reset),
    .load_i  (piso_load),
    .shift_i (piso_shift),
    .clear_i (piso_clear),
    .din_i   (load_data),
    .sout_o  (A)
  );

  assign bit_valid = bv_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - scoreboard bench for seq_pattern_gen
module tb_seq_pattern_gen;
  import seqgen_pkg::*;

  localparam int GAP = 2;
`ifdef SEQGEN_GAP_EN
  localparam int GAPS = GAP;
`else
  localparam int GAPS = 0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [3:0] pattern, repeat_cnt;
  logic       A, bit_valid, busy, done;

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(4), .CNT_W(4), .GAP_CYC(GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .A          (A),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic is_done;
    logic val;
  } exp_t;

  exp_t       exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         z_cnt = 0;
  int         det_n = 0;
  logic [3:0] det_sh = 4'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  task automatic push_bits(input logic [3:0] pat, input int reps);
    for (int r = 0; r < reps; r++)
      for (int i = 3; i >= 0; i--)
        exp_q.push_back('{is_done: 1'b0, val: pat[i]});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a bit or a done pulse.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        if (bit_valid) begin
          if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("bit_order", e.is_done, 0);
            chk("bit_A", A, e.val);
          end
          det_sh = {det_sh[2:0], A};
          det_n++;
          if (det_n >= 4 && det_sh == 4'b1101) z_cnt++;
        end else begin
          chk("idle_A", A, 0);
        end
        if (!busy) begin
          det_sh = 4'b0;
          det_n  = 0;
        end
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("done_order", e.is_done, 1);
          end
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  // Called at a negedge while the DUT is idle; returns on the idle cycle after done.
  task automatic send(input string name, input logic [3:0] pat, input int reps);
    int b0, d0, cyc, exp_busy;
    exp_busy = (reps == 0) ? 1 : reps * 4 + (reps - 1) * GAPS;
    b0 = busy_cnt;
    d0 = done_cnt;
    push_bits(pat, reps);
    exp_q.push_back('{is_done: 1'b1, val: 1'b0});
    pattern    = pat;
    repeat_cnt = 4'(reps);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    pattern    = ~pat;
    repeat_cnt = 4'd0;
    chk({name, "_first_busy"}, busy, 1);
    chk({name, "_first_valid"}, bit_valid, (reps != 0));
    cyc = 1;
    while (done_cnt == d0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_cycle"}, cyc, exp_busy + 1);
    @(negedge clk);
    chk({name, "_busy_total"}, busy_cnt - b0, exp_busy);
    chk({name, "_done_pulses"}, done_cnt - d0, 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int b0, d0, z0, cyc;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 4'b0; repeat_cnt = 4'b0;
    repeat (2) @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_valid", bit_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    send("single", DEFAULT_PATTERN, 1);
    send("rep3", 4'b1101, 3);
    send("rep2_0110", 4'b0110, 2);
    send("rep15", 4'b1001, 15);

    // Abort on the 2nd bit of repetition 2; start asserted alongside must lose.
    d0 = done_cnt;
    push_bits(4'b1101, 1);
    exp_q.push_back('{is_done: 1'b0, val: 1'b1});
    exp_q.push_back('{is_done: 1'b0, val: 1'b1});
    pattern = 4'b1101; repeat_cnt = 4'd3; start = 1'b1;
    cyc = 0;
    while (cyc < 6 + GAPS) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    abort = 1'b1; start = 1'b1; pattern = 4'b0101;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort_A", A, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", bit_valid, 0);
    chk("abort_queue", exp_q.size(), 0);
    send("after_abort", 4'b0110, 2);
    chk("abort_no_done", done_cnt - d0, 1);

    // Asynchronous reset in the middle of a transfer.
    d0 = done_cnt;
    exp_q.push_back('{is_done: 1'b0, val: 1'b1});
    exp_q.push_back('{is_done: 1'b0, val: 1'b1});
    pattern = 4'b1101; repeat_cnt = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_A", A, 0);
    chk("arst_busy", busy, 0);
    chk("arst_valid", bit_valid, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    chk("arst_queue", exp_q.size(), 0);
    chk("arst_no_done", done_cnt - d0, 0);
    @(negedge clk);
    send("zero_rep", 4'b1111, 0);

    // Loopback into a 1101 detector model; start held high through busy and done.
    b0 = busy_cnt; d0 = done_cnt; z0 = z_cnt;
    push_bits(DEFAULT_PATTERN, 2);
    exp_q.push_back('{is_done: 1'b1, val: 1'b0});
    pattern = DEFAULT_PATTERN; repeat_cnt = 4'd2; start = 1'b1;
    @(negedge clk);
    pattern = 4'b0000; repeat_cnt = 4'd5;
    cyc = 1;
    while (done_cnt == d0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("loop_done_cycle", cyc, 8 + GAPS + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("loop_idle_busy", busy, 0);
    chk("loop_z_count", z_cnt - z0, 2);
    chk("loop_busy_total", busy_cnt - b0, 8 + GAPS);
    chk("loop_done_pulses", done_cnt - d0, 1);
    chk("loop_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
